// File: rtl/countdown_timer4.sv
// countdown_timer4: 4-bit loadable down-counter with one-shot and periodic modes.
// A three-state controller (IDLE, RUN, DONE) sequences load, start, pause and
// stop; a registered single-cycle terminal-count pulse marks each expiry.
// All state, including the reload register, is cleared synchronously.
module countdown_timer4 (
    input  logic       clk,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       auto_reload,
    output logic [3:0] counter,
    output logic       busy,
    output logic       done,
    output logic       tc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic [3:0] reload_q, reload_d;
    logic       tc_q, tc_d;

    // Register update; clear overrides every other input in every state.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so update order inside this block does not matter.
        if (clear) begin
            state_q  <= S_IDLE;
            count_q  <= 4'd0;
            reload_q <= 4'd0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    // Next-state, count, reload and terminal-count decisions.
    always_comb begin
        // NOTE: every signal gets a hold/default value first so that no path
        // through the case below leaves one unassigned (which would infer a latch).
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (load) begin
                    // Load wins over start and always lands in IDLE.
                    count_d  = load_value;
                    reload_d = load_value;
                    state_d  = S_IDLE;
                end else if (start && (count_q != 4'd0)) begin
                    state_d = S_RUN;
                end
                // start with a zero count is ignored: state and count hold.
            end

            S_RUN: begin
                if (stop) begin
                    // Abort with the current count preserved.
                    state_d = S_IDLE;
                end else if (!pause) begin
                    if (count_q > 4'd1) begin
                        count_d = count_q - 4'd1;
                    end else if (count_q == 4'd1) begin
                        tc_d = 1'b1;
                        if (auto_reload) begin
                            // Periodic: restart from the reload value, stay in RUN.
                            count_d = reload_q;
                        end else begin
                            count_d = 4'd0;
                            state_d = S_DONE;
                        end
                    end else begin
                        // A zero count in RUN is unreachable through load/start;
                        // retire to DONE rather than wrap to 15.
                        state_d = S_DONE;
                    end
                end
                // pause without stop freezes the count and keeps tc low.
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign counter = count_q;
    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign tc      = tc_q;

endmodule

// File: tb/tb_countdown_timer4.sv
// Self-checking bench for countdown_timer4: directed scenarios followed by a
// randomized phase, all compared against a behavioural timer model.
module tb_countdown_timer4;

    logic       clk;
    logic       clear;
    logic       load;
    logic [3:0] load_value;
    logic       start;
    logic       stop;
    logic       pause;
    logic       auto_reload;
    logic [3:0] counter;
    logic       busy;
    logic       done;
    logic       tc;

    countdown_timer4 dut (
        .clk         (clk),
        .clear       (clear),
        .load        (load),
        .load_value  (load_value),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .auto_reload (auto_reload),
        .counter     (counter),
        .busy        (busy),
        .done        (done),
        .tc          (tc)
    );

    always #5 clk = ~clk;

    // Behavioural model: the timer is "running", "finished" or neither.
    int    m_count;
    int    m_reload;
    bit    m_running;
    bit    m_finished;
    bit    m_tc;

    int    n_checks;
    int    n_pass;
    int    tc_seen;
    string scen;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Apply one set of inputs for one clock edge, advance the model by the
    // timer rules, then compare all outputs just after the edge.
    task automatic step(input logic c, input logic l, input logic [3:0] lv,
                        input logic s, input logic sp, input logic p, input logic ar);
        clear       = c;
        load        = l;
        load_value  = lv;
        start       = s;
        stop        = sp;
        pause       = p;
        auto_reload = ar;
        @(posedge clk);
        m_tc = 1'b0;
        if (c) begin
            m_count    = 0;
            m_reload   = 0;
            m_running  = 1'b0;
            m_finished = 1'b0;
        end else if (m_running) begin
            if (sp) begin
                m_running = 1'b0;
            end else if (!p) begin
                if (m_count == 1) begin
                    m_tc = 1'b1;
                    if (ar) begin
                        m_count = m_reload;
                    end else begin
                        m_count    = 0;
                        m_running  = 1'b0;
                        m_finished = 1'b1;
                    end
                end else begin
                    m_count = m_count - 1;
                end
            end
        end else if (l) begin
            m_count    = int'(lv);
            m_reload   = int'(lv);
            m_finished = 1'b0;
        end else if (s && m_count != 0) begin
            m_running  = 1'b1;
            m_finished = 1'b0;
        end
        #1;
        if (tc === 1'b1) tc_seen++;
        check({scen, ":counter"}, counter, 4'(m_count));
        check({scen, ":busy"}, {3'b0, busy}, {3'b0, m_running});
        check({scen, ":done"}, {3'b0, done}, {3'b0, m_finished});
        check({scen, ":tc"}, {3'b0, tc}, {3'b0, m_tc});
    endtask

    task automatic idle_step(input logic ar);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, ar);
    endtask

    initial begin
        clk         = 1'b0;
        clear       = 1'b0;
        load        = 1'b0;
        load_value  = 4'd0;
        start       = 1'b0;
        stop        = 1'b0;
        pause       = 1'b0;
        auto_reload = 1'b0;
        m_count     = 0;
        m_reload    = 0;
        m_running   = 1'b0;
        m_finished  = 1'b0;
        m_tc        = 1'b0;
        n_checks    = 0;
        n_pass      = 0;
        tc_seen     = 0;

        // Reset state.
        scen = "reset";
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_counter", counter, 4'd0);
        check("reset_flags", {1'b0, busy, done, tc}, 4'b0000);

        // One-shot countdown from 5.
        scen = "oneshot";
        step(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("oneshot_first", counter, 4'd5);
        tc_seen = 0;
        for (int i = 0; i < 5; i++) idle_step(1'b0);
        check("oneshot_end_cnt", counter, 4'd0);
        check("oneshot_end_tc", {3'b0, tc}, 4'd1);
        idle_step(1'b0);
        check("oneshot_tc_pulses", 4'(tc_seen), 4'd1);
        check("oneshot_done_busy", {2'b0, done, busy}, 4'b0010);

        // Periodic mode with reload 3: leaves DONE via load.
        scen = "periodic";
        step(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tc_seen = 0;
        for (int i = 0; i < 9; i++) idle_step(1'b1);
        check("periodic_tc_pulses", 4'(tc_seen), 4'd3);
        check("periodic_cnt", counter, 4'd3);
        check("periodic_busy", {3'b0, busy}, 4'd1);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Pause at 6 for four cycles, then stop at 3.
        scen = "pause_stop";
        step(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tc_seen = 0;
        idle_step(1'b0);
        idle_step(1'b0);
        check("pause_at", counter, 4'd6);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pause_hold", counter, 4'd6);
        idle_step(1'b0);
        check("pause_resume", counter, 4'd5);
        idle_step(1'b0);
        idle_step(1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("stop_cnt", counter, 4'd3);
        check("stop_idle", {2'b0, done, busy}, 4'b0000);
        check("stop_no_tc", 4'(tc_seen), 4'd0);

        // Zero-count start and load-over-start priority.
        scen = "priority";
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("zero_start_busy", {3'b0, busy}, 4'd0);
        step(1'b0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        check("load_prio_cnt", counter, 4'd15);
        check("load_prio_busy", {3'b0, busy}, 4'd0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("start_after_load", {3'b0, busy}, 4'd1);

        // Clear mid-run; a later start has nothing to count.
        scen = "clear_mid";
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle_step(1'b0);
        check("clear_at", counter, 4'd7);
        step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("clear_cnt", counter, 4'd0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("clear_restart", {2'b0, done, busy}, 4'b0000);

        // DONE exit through load.
        scen = "done_exit";
        step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_step(1'b0);
        check("done_reached", {3'b0, done}, 4'd1);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("done_start_ign", {2'b0, done, busy}, 4'b0010);
        step(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        check("done_load_exit", {2'b0, done, busy}, 4'b0000);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_step(1'b0);
        idle_step(1'b0);
        check("done_exit_tc", {3'b0, tc}, 4'd1);

        // Randomized traffic against the model.
        scen = "random";
        step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 7) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/countdown_timer4.md
COUNTDOWN_TIMER4 -- requirements
Module: countdown_timer4

Interface
REQ-001 The block SHALL have the port `clk`, input, width 1: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `clear`, input, width 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
REQ-003 The block SHALL have the port `load`, input, width 1: capture `load_value` into the counter and the reload register.
REQ-004 The block SHALL have the port `load_value`, input, width 4: unsigned preset value.
REQ-005 The block SHALL have the port `start`, input, width 1: begin counting down.
REQ-006 The block SHALL have the port `stop`, input, width 1: abort counting and hold the current count.
REQ-007 The block SHALL have the port `pause`, input, width 1: inhibit decrement while high.
REQ-008 The block SHALL have the port `auto_reload`, input, width 1: 1 = periodic mode, 0 = one-shot mode.
REQ-009 The block SHALL have the port `counter`, output, width 4: current count, registered.
REQ-010 The block SHALL have the port `busy`, output, width 1: high while in RUN.
REQ-011 The block SHALL have the port `done`, output, width 1: high while in DONE.
REQ-012 The block SHALL have the port `tc`, output, width 1: single-cycle terminal-count pulse, registered.

Function
REQ-013 The block SHALL implement an FSM with three states: IDLE, RUN, DONE; `busy` = (state==RUN) and `done` = (state==DONE).
REQ-014 In IDLE or DONE, `load`=1 SHALL set counter <= `load_value` and reload_reg <= `load_value` at the clock edge, with next state IDLE.
REQ-015 `load` SHALL take priority over `start` in the same cycle, and `load` SHALL be ignored in RUN.
REQ-016 In IDLE or DONE with `load`=0 and `start`=1: if counter != 0, the next state SHALL be RUN; if counter == 0, `start` SHALL be ignored and the state SHALL be held.
REQ-017 Each rising edge in RUN with `pause`=0, `stop`=0 and counter > 1 SHALL decrement counter by 1.
REQ-018 In RUN, `pause`=1 SHALL freeze counter, leave the state at RUN and keep `tc`=0.
REQ-019 In RUN, `stop`=1 SHALL move to IDLE with counter held; `stop` SHALL have priority over `pause` and over the decrement.
REQ-020 In RUN with counter==1, `pause`=0, `stop`=0 and `auto_reload`=0, the edge SHALL set counter <= 0, `tc` <= 1 and next state DONE.
REQ-021 In RUN with counter==1, `pause`=0, `stop`=0 and `auto_reload`=1, the edge SHALL set counter <= reload_reg, `tc` <= 1 and remain in RUN.
REQ-022 The periodic `tc` interval SHALL equal reload_reg unpaused RUN cycles.
REQ-023 `tc` SHALL be 0 in every cycle not covered by REQ-020 or REQ-021.
REQ-024 In one-shot mode, from a `start` sampled at edge E0 with counter=V, `tc`=1 and counter=0 SHALL appear after edge E0+V when no pause occurs.
REQ-025 The counter SHALL never wrap: no decrement below 0, and no 0->15 transition.
REQ-026 `start` in RUN SHALL be ignored.
REQ-027 `auto_reload` SHALL be sampled only at the counter==1 edge and MAY change at any time.
REQ-028 reload_reg SHALL change only via `load` in IDLE or DONE, and SHALL therefore be stable during RUN.
REQ-029 In DONE, counter SHALL stay 0 until `load` or `clear`; `start` in DONE without `load` SHALL be ignored, as counter==0.

Reset
REQ-030 `clear`=1 at a rising edge SHALL force state IDLE, counter=0, reload_reg=0, `tc`=0, `busy`=0 and `done`=0.
REQ-031 `clear` SHALL have priority over all other inputs in every state, including mid-RUN.
REQ-032 `clear` SHALL NOT affect outputs between clock edges; there SHALL be no asynchronous path.

Verification
REQ-033 The bench SHALL cover one-shot countdown: clear; load 4'd5; start; pause=0 -> counter 5,4,3,2,1,0 on successive edges, `tc`=1 for exactly one cycle with counter=0, then `done`=1 and `busy`=0.
REQ-034 The bench SHALL cover periodic mode: load 4'd3, auto_reload=1, start -> counter 3,2,1,3,2,1,...; `tc` pulses every 3 cycles; `busy` stays 1.
REQ-035 The bench SHALL cover pause and stop: load 4'd8, start, pause high for 4 cycles at counter=6 -> counter holds 6 for 4 cycles, then resumes at 5; stop at counter=3 -> IDLE, counter=3, `tc` never asserted.
REQ-036 The bench SHALL cover zero and priority: clear, then start -> stays IDLE, counter=0; load=1 with start=1 and load_value=4'd15 -> IDLE, counter=15; next start -> RUN.
REQ-037 The bench SHALL cover clear mid-run: load 4'd10, start, assert clear at counter=7 -> next edge counter=0, IDLE, `tc`=0; a subsequent start is ignored, because reload_reg=0 and counter=0.
REQ-038 The bench SHALL cover DONE exit: after a one-shot completes, load 4'd2 then start -> counter 2,1,0 with `tc` on the last edge; `done` deasserts on the load edge.
